uart_rx_fifo: RTL and testbench

Parametrised successor to the team's fixed-format UART receiver. Oversampled, programmable-baud RX path with mid-bit majority voting, per-character parity/framing status, break detection and a first-word-fall-through receive FIFO. RTS flow control is driven from the FIFO fill level with hysteresis. Sits between the pad-level rx line and the host/scoreboard side of the UART.

---
 rtl/uart_rx_fifo.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Oversampled UART receive path with a first-word-fall-through receive FIFO.
// Each bit is decided by a majority vote of three samples taken around mid-bit.
// Every completed frame is pushed with its parity and framing status. A break
// (all-zero character with a framing error) is flagged, and the receiver then
// waits for the line to return high. RTS is driven from the FIFO fill level
// with hysteresis.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   baud_div            clk cycles per oversample tick (0 behaves as 1)
//   rx                  serial input, idle high
//   data_bit_num        00=5, 01=6, 10=7, 11=8 data bits
//   stop_bit_num        0=1 stop bit, 1=2 stop bits
//   parity_en/type      parity present / 0=even, 1=odd
//   rd_ready            consumer accepts the head entry
//   clear_ovr           clears the sticky overrun flag
//   rd_valid            FIFO non-empty
//   rd_data             head data; rd_parity_error and rd_framing_error are its flags
//   rx_done             1-cycle pulse for every completed frame (pushed or dropped)
//   break_det           1-cycle pulse when a break is detected
//   overrun             sticky: a frame was dropped because the FIFO was full
//   fifo_level          current entry count
//   rts_n               0 = peer may send
//   dbg_state           current receiver FSM state
//
// Read handshake: an entry transfers on every rising clk edge where
// rd_valid && rd_ready. rd_valid never depends on rd_ready. While rd_valid is
// high, the head entry is stable until it is popped.
module uart_rx_fifo #(
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int DIV_W       = 16,
    parameter int RTS_HIGH    = 12,
    parameter int RTS_LOW     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DIV_W-1:0]                   baud_div,
    input  logic                               rx,
    input  logic [1:0]                         data_bit_num,
    input  logic                               stop_bit_num,
    input  logic                               parity_en,
    input  logic                               parity_type,
    input  logic                               rd_ready,
    input  logic                               clear_ovr,
    output logic                               rd_valid,
    output logic [7:0]                         rd_data,
    output logic                               rd_parity_error,
    output logic                               rd_framing_error,
    output logic                               rx_done,
    output logic                               break_det,
    output logic                               overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               rts_n,
    output logic [2:0]                         dbg_state
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OS_W  = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] SMP_A   = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] SMP_B   = OS_W'(OVERSAMPLE / 2);
    localparam logic [OS_W-1:0] SMP_C   = OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP1, STOP2, DONE, BREAK_WAIT
    } state_t;

    // ---------------- rx synchroniser ----------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '1;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
    assign rx_s = sync_q[SYNC_STAGES-1];

    // ---------------- oversample tick ----------------
    // Down-counter; baud_div is only looked at when the counter reloads.
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d, div_reload;
    logic             tick;

    assign div_reload = (baud_div == '0) ? '0 : baud_div - DIV_W'(1);
    assign tick       = (div_cnt_q == '0);
    assign div_cnt_d  = tick ? div_reload : div_cnt_q - DIV_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) div_cnt_q <= '0;
        else       div_cnt_q <= div_cnt_d;
    end

    // ---------------- receiver FSM ----------------
    state_t            state_q, state_d;
    logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        data_q, data_d;
    logic              par_err_q, par_err_d;
    logic              frm_err_q, frm_err_d;
    logic              par_bit_q, par_bit_d;
    logic [1:0]        vote_q, vote_d;
    logic [1:0]        nbits_q, nbits_d;
    logic              stop2_q, stop2_d;
    logic              pen_q, pen_d;
    logic              ptype_q, ptype_d;

    logic       active, mid, smp, is_break, push;
    logic [2:0] last_bit;

    assign active   = (state_q == START) || (state_q == DATA) || (state_q == PARITY) ||
                      (state_q == STOP1) || (state_q == STOP2);
    // Decision point: third vote sample; the first two were captured on earlier ticks.
    assign mid      = active && tick && (os_cnt_q == SMP_C);
    assign smp      = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
    assign last_bit = {1'b0, nbits_q} + 3'd4;
    assign is_break = (data_q == 8'h00) && !(pen_q && par_bit_q) && frm_err_q;
    assign push     = (state_q == DONE);

    always_comb begin
        state_d   = state_q;
        os_cnt_d  = os_cnt_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        par_bit_d = par_bit_q;
        vote_d    = vote_q;
        nbits_d   = nbits_q;
        stop2_d   = stop2_q;
        pen_d     = pen_q;
        ptype_d   = ptype_q;

        if (active && tick) begin
            os_cnt_d = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
            if (os_cnt_q == SMP_A) vote_d[0] = rx_s;
            if (os_cnt_q == SMP_B) vote_d[1] = rx_s;
        end

        unique case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d   = START;
                    os_cnt_d  = '0;
                    bit_cnt_d = '0;
                    data_d    = '0;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                    par_bit_d = 1'b0;
                    nbits_d   = data_bit_num;
                    stop2_d   = stop_bit_num;
                    pen_d     = parity_en;
                    ptype_d   = parity_type;
                end
            end
            START: begin
                if (mid) state_d = smp ? IDLE : DATA;
            end
            DATA: begin
                if (mid) begin
                    data_d[bit_cnt_q] = smp;
                    if (bit_cnt_q == last_bit) state_d = pen_q ? PARITY : STOP1;
                    else                       bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: begin
                if (mid) begin
                    par_bit_d = smp;
                    par_err_d = ((^data_q) ^ smp) != ptype_q;
                    state_d   = STOP1;
                end
            end
            STOP1: begin
                if (mid) begin
                    if (!smp) frm_err_d = 1'b1;
                    state_d = stop2_q ? STOP2 : DONE;
                end
            end
            STOP2: begin
                if (mid) begin
                    if (!smp) frm_err_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = is_break ? BREAK_WAIT : IDLE;
            end
            BREAK_WAIT: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            data_q    <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            par_bit_q <= 1'b0;
            vote_q    <= '1;
            nbits_q   <= '0;
            stop2_q   <= 1'b0;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            os_cnt_q  <= os_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            par_bit_q <= par_bit_d;
            vote_q    <= vote_d;
            nbits_q   <= nbits_d;
            stop2_q   <= stop2_d;
            pen_q     <= pen_d;
            ptype_q   <= ptype_d;
        end
    end

    assign rx_done   = push;
    assign break_det = push && is_break;
    assign dbg_state = state_q;

    // ---------------- receive FIFO ----------------
    logic [9:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] count_q, count_d;
    logic             full, pop, push_ok, drop;
    logic [9:0]       head;
    logic             overrun_q, rts_q;

    assign full     = (count_q == LVL_W'(FIFO_DEPTH));
    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid && rd_ready;
    // When full, a pop in the same cycle frees the slot the push needs.
    assign push_ok  = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + LVL_W'(1);
        else if (!push_ok && pop) count_d = count_q - LVL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= {data_q, par_err_q, frm_err_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            rts_q     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            // A new drop wins over a simultaneous clear.
            if (drop)           overrun_q <= 1'b1;
            else if (clear_ovr) overrun_q <= 1'b0;
            // Hysteresis on the registered level; holds between the thresholds.
            if (count_q >= LVL_W'(RTS_HIGH))     rts_q <= 1'b1;
            else if (count_q <= LVL_W'(RTS_LOW)) rts_q <= 1'b0;
        end
    end

    assign head             = mem_q[rd_ptr_q];
    assign rd_data          = rd_valid ? head[9:2] : 8'h00;
    assign rd_parity_error  = rd_valid & head[1];
    assign rd_framing_error = rd_valid & head[0];
    assign fifo_level       = count_q;
    assign overrun          = overrun_q;
    assign rts_n            = rts_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo. Frames are built bit by bit from the
// character format; the expected FIFO contents come from a capacity-limited
// queue of the characters sent.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] baud_div;
    logic        rx;
    logic [1:0]  data_bit_num;
    logic        stop_bit_num;
    logic        parity_en;
    logic        parity_type;
    logic        rd_ready;
    logic        clear_ovr;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        rd_parity_error;
    logic        rd_framing_error;
    logic        rx_done;
    logic        break_det;
    logic        overrun;
    logic [4:0]  fifo_level;
    logic        rts_n;
    logic [2:0]  dbg_state;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int brk_cnt = 0;
    int bit_clks = 64;
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rx_fifo #(.OVERSAMPLE(16), .FIFO_DEPTH(DEPTH), .DIV_W(16),
                   .RTS_HIGH(12), .RTS_LOW(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .baud_div(baud_div), .rx(rx),
        .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
        .parity_en(parity_en), .parity_type(parity_type),
        .rd_ready(rd_ready), .clear_ovr(clear_ovr),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .rd_parity_error(rd_parity_error), .rd_framing_error(rd_framing_error),
        .rx_done(rx_done), .break_det(break_det), .overrun(overrun),
        .fifo_level(fifo_level), .rts_n(rts_n), .dbg_state(dbg_state)
    );

    // Pulse counters
    always @(negedge clk) begin
        if (rx_done === 1'b1)   done_cnt++;
        if (break_det === 1'b1) brk_cnt++;
    end

    // Watchdog
    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        rx    = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);
        exp_q.delete();
    endtask

    task automatic set_fmt(input int nbits, input bit pen, input bit podd, input int nstop);
        data_bit_num = 2'(nbits - 5);
        parity_en    = pen;
        parity_type  = podd;
        stop_bit_num = (nstop == 2);
    endtask

    task automatic set_baud(input int div);
        baud_div = 16'(div);
        bit_clks = ((div == 0) ? 1 : div) * 16;
        idle(2 * bit_clks);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    // Sends one frame in the current format and records what the FIFO should hold.
    task automatic send_frame(input logic [7:0] data, input bit flip_par, input bit bad_stop);
        int nbits = int'(data_bit_num) + 5;
        int nstop = stop_bit_num ? 2 : 1;
        logic [7:0] dm = 8'h00;
        logic p;
        for (int i = 0; i < nbits; i++) dm[i] = data[i];
        p = (^dm) ^ parity_type ^ flip_par;
        send_bit(1'b0);
        for (int i = 0; i < nbits; i++) send_bit(dm[i]);
        if (parity_en) send_bit(p);
        for (int i = 0; i < nstop; i++) send_bit(!bad_stop);
        rx = 1'b1;
        if (exp_q.size() < DEPTH) exp_q.push_back({dm, parity_en & flip_par, bad_stop});
    endtask

    task automatic pop_entry(output logic [9:0] got, output bit ok);
        int w = 0;
        while (rd_valid !== 1'b1 && w < 4000) begin
            @(negedge clk);
            w++;
        end
        ok  = (rd_valid === 1'b1);
        got = {rd_data, rd_parity_error, rd_framing_error};
        if (ok) begin
            rd_ready = 1'b1;
            @(negedge clk);
            rd_ready = 1'b0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; rx = 1'b1; rd_ready = 1'b0; clear_ovr = 1'b0;
        baud_div = 16'd4; bit_clks = 64;
        set_fmt(8, 0, 0, 1);
        idle(3);
        reset = 1'b0;
        idle(1);
        checks++;
        if (rd_valid !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL reset_fifo: rd_valid=%b level=%0d, want 0 and 0", rd_valid, fifo_level);
        end
        checks++;
        if ({rd_data, rd_parity_error, rd_framing_error} !== 10'h000) begin
            errors++;
            $display("FAIL reset_head: data=%h pe=%b fe=%b, want all 0", rd_data, rd_parity_error, rd_framing_error);
        end
        checks++;
        if ({rx_done, break_det, overrun, rts_n} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: done=%b brk=%b ovr=%b rts_n=%b, want 0000", rx_done, break_det, overrun, rts_n);
        end
        exp_q.delete();
    endtask

    task automatic test_8n1();
        logic [9:0] got, exp;
        bit ok;
        int d0 = done_cnt;
        set_fmt(8, 0, 0, 1);
        send_frame(8'hA5, 0, 0);
        idle(100);
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL 8n1_done: pulses=%0d, want 1", done_cnt - d0);
        end
        checks++;
        if (rd_valid !== 1'b1 || fifo_level !== 5'd1) begin
            errors++;
            $display("FAIL 8n1_held: rd_valid=%b level=%0d, want 1 and 1", rd_valid, fifo_level);
        end
        pop_entry(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL 8n1_entry: got data=%h pe=%b fe=%b valid=%b, want data=%h pe=%b fe=%b",
                     got[9:2], got[1], got[0], ok, exp[9:2], exp[1], exp[0]);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_empty: rd_valid=%b after pop, want 0", rd_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] got, exp;
        bit ok;
        set_fmt(7, 1, 0, 2);
        send_frame(8'h55, 0, 0);
        send_frame(8'h2A, 0, 0);
        idle(bit_clks);
        send_frame(8'h55, 1, 0);
        idle(50);
        checks++;
        if (fifo_level !== 5'd3) begin
            errors++;
            $display("FAIL 7e2_level: level=%0d, want 3", fifo_level);
        end
        for (int i = 0; i < 3; i++) begin
            pop_entry(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL 7e2_entry%0d: got data=%h pe=%b fe=%b valid=%b, want data=%h pe=%b fe=%b",
                         i, got[9:2], got[1], got[0], ok, exp[9:2], exp[1], exp[0]);
            end
        end
    endtask

    task automatic test_framing();
        logic [9:0] got, exp;
        bit ok;
        int b0 = brk_cnt;
        set_fmt(5, 1, 1, 1);
        send_frame(8'h1F, 0, 1);
        idle(bit_clks);
        pop_entry(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL 5o1_entry: got data=%h pe=%b fe=%b valid=%b, want data=%h pe=%b fe=%b",
                     got[9:2], got[1], got[0], ok, exp[9:2], exp[1], exp[0]);
        end
        checks++;
        if (brk_cnt != b0) begin
            errors++;
            $display("FAIL 5o1_no_break: break pulses=%0d, want 0", brk_cnt - b0);
        end
    endtask

    task automatic test_break();
        logic [9:0] got, exp;
        bit ok;
        int b0 = brk_cnt;
        int d0 = done_cnt;
        set_fmt(8, 0, 0, 1);
        rx = 1'b0;
        idle(3 * 10 * bit_clks);
        exp_q.push_back({8'h00, 1'b0, 1'b1});
        checks++;
        if (brk_cnt - b0 != 1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL break_pulses: break=%0d done=%0d, want 1 and 1", brk_cnt - b0, done_cnt - d0);
        end
        checks++;
        if (fifo_level !== 5'd1) begin
            errors++;
            $display("FAIL break_level_low: level=%0d, want 1", fifo_level);
        end
        rx = 1'b1;
        idle(2 * bit_clks);
        checks++;
        if (fifo_level !== 5'd1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL break_release: level=%0d done=%0d, want 1 and 1", fifo_level, done_cnt - d0);
        end
        pop_entry(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL break_entry: got data=%h pe=%b fe=%b valid=%b, want data=%h pe=%b fe=%b",
                     got[9:2], got[1], got[0], ok, exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic test_overrun_rts();
        logic [9:0] got, exp;
        bit ok;
        int d0 = done_cnt;
        set_fmt(8, 0, 0, 1);
        rd_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            send_frame(8'($urandom_range(0, 255)), 0, 0);
            if (i == 10) begin
                checks++;
                if (rts_n !== 1'b0) begin
                    errors++;
                    $display("FAIL rts_below_high: rts_n=%b at level %0d, want 0", rts_n, fifo_level);
                end
            end
            if (i == 11) begin
                checks++;
                if (rts_n !== 1'b1) begin
                    errors++;
                    $display("FAIL rts_at_high: rts_n=%b at level %0d, want 1", rts_n, fifo_level);
                end
            end
        end
        checks++;
        if (fifo_level !== 5'd16 || overrun !== 1'b1 || rts_n !== 1'b1) begin
            errors++;
            $display("FAIL ovr_full: level=%0d overrun=%b rts_n=%b, want 16 1 1", fifo_level, overrun, rts_n);
        end
        checks++;
        if (done_cnt - d0 != 17) begin
            errors++;
            $display("FAIL ovr_done: pulses=%0d, want 17", done_cnt - d0);
        end
        for (int i = 0; i < 16; i++) begin
            pop_entry(got, ok);
            exp = exp_q.pop_front();
            checks++;
            if (!ok || got !== exp) begin
                errors++;
                $display("FAIL ovr_entry%0d: got data=%h pe=%b fe=%b valid=%b, want data=%h pe=%b fe=%b",
                         i, got[9:2], got[1], got[0], ok, exp[9:2], exp[1], exp[0]);
            end
            if (i == 6) begin
                idle(2);
                checks++;
                if (rts_n !== 1'b1) begin
                    errors++;
                    $display("FAIL rts_hold: rts_n=%b at level %0d, want 1", rts_n, fifo_level);
                end
            end
            if (i == 7) begin
                checks++;
                if (rts_n !== 1'b1) begin
                    errors++;
                    $display("FAIL rts_registered: rts_n=%b same cycle as level 8, want 1", rts_n);
                end
                idle(1);
                checks++;
                if (rts_n !== 1'b0) begin
                    errors++;
                    $display("FAIL rts_at_low: rts_n=%b at level %0d, want 0", rts_n, fifo_level);
                end
                checks++;
                if (overrun !== 1'b1) begin
                    errors++;
                    $display("FAIL ovr_sticky: overrun=%b, want 1", overrun);
                end
                clear_ovr = 1'b1;
                idle(1);
                clear_ovr = 1'b0;
                idle(1);
                checks++;
                if (overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL ovr_clear: overrun=%b, want 0", overrun);
                end
            end
        end
        checks++;
        if (rd_valid !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL ovr_drained: rd_valid=%b level=%0d, want 0 and 0", rd_valid, fifo_level);
        end
    endtask

    task automatic test_glitch();
        int d0 = done_cnt;
        set_fmt(8, 0, 0, 1);
        rx = 1'b0;
        idle(1);
        rx = 1'b1;
        idle(3 * bit_clks);
        checks++;
        if (fifo_level !== 5'd0 || rd_valid !== 1'b0 || done_cnt != d0) begin
            errors++;
            $display("FAIL glitch: level=%0d rd_valid=%b done=%0d, want 0 0 0", fifo_level, rd_valid, done_cnt - d0);
        end
    endtask

    task automatic test_reset_midframe();
        logic [9:0] got, exp;
        bit ok;
        set_fmt(8, 0, 0, 1);
        send_frame(8'h3C, 0, 0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b0;
        idle(bit_clks / 2);
        do_reset();
        checks++;
        if (rd_valid !== 1'b0 || fifo_level !== 5'd0) begin
            errors++;
            $display("FAIL midreset_empty: rd_valid=%b level=%0d, want 0 and 0", rd_valid, fifo_level);
        end
        send_frame(8'hC3, 0, 0);
        pop_entry(got, ok);
        exp = exp_q.pop_front();
        checks++;
        if (!ok || got !== exp) begin
            errors++;
            $display("FAIL midreset_entry: got data=%h pe=%b fe=%b valid=%b, want data=%h pe=%b fe=%b",
                     got[9:2], got[1], got[0], ok, exp[9:2], exp[1], exp[0]);
        end
    endtask

    task automatic test_random();
        logic [9:0] got, exp;
        bit ok;
        for (int r = 0; r < 5; r++) begin
            int d0 = done_cnt;
            int n = $urandom_range(1, 4);
            int pen = $urandom_range(0, 1);
            set_baud($urandom_range(0, 4));
            set_fmt($urandom_range(5, 8), pen[0], 1'($urandom_range(0, 1)), $urandom_range(1, 2));
            for (int f = 0; f < n; f++)
                send_frame(8'($urandom_range(0, 255)), pen[0] & 1'($urandom_range(0, 1)), 0);
            idle(bit_clks);
            checks++;
            if (done_cnt - d0 != n) begin
                errors++;
                $display("FAIL rand%0d_done: pulses=%0d, want %0d", r, done_cnt - d0, n);
            end
            for (int f = 0; f < n; f++) begin
                pop_entry(got, ok);
                exp = exp_q.pop_front();
                checks++;
                if (!ok || got !== exp) begin
                    errors++;
                    $display("FAIL rand%0d_entry%0d: got data=%h pe=%b fe=%b valid=%b, want data=%h pe=%b fe=%b",
                             r, f, got[9:2], got[1], got[0], ok, exp[9:2], exp[1], exp[0]);
                end
            end
        end
        set_baud(4);
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_back_to_back();
        test_framing();
        test_break();
        test_overrun_rts();
        test_glitch();
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
